// File: rtl/video_pkg.sv
// Shared definitions for the tile video unit: register map, CTRL bit layout,
// tile-attribute RAM geometry and the tattr DMA state encoding.
package video_pkg;

  localparam int TATTR_SIZE = 1024;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write-side bits
  localparam int CTRL_START      = 0;
  localparam int CTRL_WAIT_VS    = 1;
  localparam int CTRL_CLEAR_DONE = 2;
  localparam int CTRL_IRQ_EN     = 3;
  localparam int CTRL_ABORT      = 4;

  // CTRL read-side bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_REQ     = 2'd2,
    ST_WRITE   = 2'd3
  } dma_state_e;

  function automatic logic [31:0] ctrl_status(input logic busy, input logic done,
                                              input logic irq_en);
    logic [31:0] r;
    r              = 32'd0;
    r[STAT_BUSY]   = busy;
    r[STAT_DONE]   = done;
    r[CTRL_IRQ_EN] = irq_en;
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a history flop
// that yields a one-cycle pulse on each synchronised falling edge.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchroniser chain plus edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/tile_attr_dma.sv
// Byte-copy DMA from system memory into the tile-attribute RAM, optionally
// deferred to the next vertical sync for tear-free tile-map updates.
module tile_attr_dma #(
  parameter int TATTR_SIZE = video_pkg::TATTR_SIZE,
  parameter int ADDR_W     = $clog2(TATTR_SIZE),
  parameter int LEN_W      = ADDR_W + 1
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  input  logic              reg_wenable,
  output logic [31:0]       reg_rdata,
  output logic [31:0]       mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] tattr_addr,
  output logic [7:0]        tattr_wdata,
  output logic              tattr_wenable,
  input  logic              v_sync,
  output logic              busy,
  output logic              irq
);

  import video_pkg::*;

  dma_state_e        state_r, state_s;
  logic [31:0]       src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt_r, cnt_s;
  logic              done_r, done_s;
  logic              irq_en_r, irq_en_s;
  logic              abort_pend_r, abort_pend_s;
  logic              vs_fall_s;
  logic              ctrl_wr_s, start_s, abort_s, last_s;

  sync_edge_detect #(.RST_VAL(1'b1)) u_vs_sync (
    .clk   (wclk),
    .rst_n (rst_n),
    .d     (v_sync),
    .fall  (vs_fall_s)
  );

  assign ctrl_wr_s = reg_wenable && (reg_addr == REG_CTRL);
  assign start_s   = ctrl_wr_s && reg_wdata[CTRL_START];
  assign abort_s   = ctrl_wr_s && reg_wdata[CTRL_ABORT];
  assign last_s    = ((cnt_r + LEN_W'(1)) == len_r);

  // next-state, byte counter, done flag and abort bookkeeping
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    abort_pend_s = abort_pend_r;
    irq_en_s     = ctrl_wr_s ? reg_wdata[CTRL_IRQ_EN] : irq_en_r;
    if (ctrl_wr_s && reg_wdata[CTRL_CLEAR_DONE]) begin
      done_s = 1'b0;
    end else begin
      done_s = done_r;
    end
    case (state_r)
      ST_IDLE: begin
        abort_pend_s = 1'b0;
        if (start_s) begin
          cnt_s = {LEN_W{1'b0}};
          if (len_r == {LEN_W{1'b0}}) begin
            done_s = 1'b1;
          end else begin
            done_s  = 1'b0;
            state_s = reg_wdata[CTRL_WAIT_VS] ? ST_WAIT_VS : ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_VS: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else if (vs_fall_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_WAIT_VS;
        end
      end
      ST_REQ: begin
        // the handshake must finish, so an abort here waits for WRITE
        if (abort_s) begin
          abort_pend_s = 1'b1;
        end else begin
          abort_pend_s = abort_pend_r;
        end
        if (mem_ack) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WRITE: begin
        cnt_s = cnt_r + LEN_W'(1);
        if (last_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else if (abort_s || abort_pend_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, control state and registered bus outputs
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {LEN_W{1'b0}};
      done_r        <= 1'b0;
      irq_en_r      <= 1'b0;
      abort_pend_r  <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'd0;
      tattr_wenable <= 1'b0;
      tattr_addr    <= {ADDR_W{1'b0}};
      tattr_wdata   <= 8'd0;
      busy          <= 1'b0;
      irq           <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      done_r        <= done_s;
      irq_en_r      <= irq_en_s;
      abort_pend_r  <= abort_pend_s;
      mem_req       <= (state_s == ST_REQ);
      tattr_wenable <= (state_s == ST_WRITE);
      busy          <= (state_s != ST_IDLE);
      irq           <= done_s & irq_en_s;
      if (state_s == ST_REQ) begin
        mem_addr <= src_r + 32'(cnt_s);
      end
      if (state_s == ST_WRITE) begin
        tattr_addr <= dst_r + cnt_s[ADDR_W-1:0];
      end
      if ((state_r == ST_REQ) && mem_ack) begin
        tattr_wdata <= mem_rdata;
      end
    end
  end

  // SRC/DST/LEN are frozen for the duration of a transfer
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      src_r <= 32'd0;
      dst_r <= {ADDR_W{1'b0}};
      len_r <= {LEN_W{1'b0}};
    end else if (reg_wenable && (state_r == ST_IDLE)) begin
      case (reg_addr)
        REG_SRC: src_r <= reg_wdata;
        REG_DST: dst_r <= reg_wdata[ADDR_W-1:0];
        REG_LEN: len_r <= reg_wdata[LEN_W-1:0];
        default: src_r <= src_r;
      endcase
    end
  end

  // register read mux
  always_comb begin
    case (reg_addr)
      REG_SRC:  reg_rdata = src_r;
      REG_DST:  reg_rdata = 32'(dst_r);
      REG_LEN:  reg_rdata = 32'(len_r);
      REG_CTRL: reg_rdata = ctrl_status(busy, done_r, irq_en_r);
      default:  reg_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_tile_attr_dma.sv
// Scoreboard bench for tile_attr_dma: expected tattr writes are queued when a
// transfer is started and retired as the DUT strobes tattr_wenable.
module tb_tile_attr_dma;

  logic        wclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic        reg_wenable = 1'b0;
  logic [31:0] reg_rdata;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [9:0]  tattr_addr;
  logic [7:0]  tattr_wdata;
  logic        tattr_wenable;
  logic        v_sync = 1'b1;
  logic        busy;
  logic        irq;

  tile_attr_dma dut (
    .wclk          (wclk),
    .rst_n         (rst_n),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wenable   (reg_wenable),
    .reg_rdata     (reg_rdata),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .tattr_addr    (tattr_addr),
    .tattr_wdata   (tattr_wdata),
    .tattr_wenable (tattr_wenable),
    .v_sync        (v_sync),
    .busy          (busy),
    .irq           (irq)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          wr_cnt = 0;
  int          req_cnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // memory model: ack after ack_delay request cycles
  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem_ack ? mem_byte(mem_addr) : 8'h00;

  always @(posedge wclk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // output monitor: retire scoreboard entries and watch request stability
  always @(negedge wclk) begin
    if (rst_n) begin
      if (tattr_wenable) begin
        wr_cnt <= wr_cnt + 1;
        if (sb.size() == 0) begin
          check("unexp_wr", 32'(tattr_addr), 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", 32'(tattr_addr), 32'(sb[0].a));
          check("wr_data", 32'(tattr_wdata), 32'(sb[0].d));
          void'(sb.pop_front());
        end
      end
      if (mem_req && prev_req && !prev_ack) check("addr_stable", mem_addr, prev_addr);
      if (mem_req) req_cnt <= req_cnt + 1;
      prev_req  <= mem_req;
      prev_ack  <= mem_ack;
      prev_addr <= mem_addr;
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr    = a;
    reg_wdata   = d;
    reg_wenable = 1'b1;
    @(posedge wclk);
    #1;
    reg_wenable = 1'b0;
    reg_wdata   = 32'd0;
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic push_xfer(input logic [31:0] src, input int dst, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.a = 10'((dst + i) % 1024);
      e.d = mem_byte(src + 32'(i));
      sb.push_back(e);
    end
  endtask

  task automatic run_until_idle(input string tag, input int limit, output int cyc);
    cyc = 0;
    @(negedge wclk);
    while (busy && cyc < limit) begin
      cyc++;
      @(negedge wclk);
    end
    if (cyc >= limit) check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic setup(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    reg_wr(2'd0, src);
    reg_wr(2'd1, dst);
    reg_wr(2'd2, len);
  endtask

  initial begin
    int cyc;
    int n;
    int base;
    int r0;

    repeat (3) @(posedge wclk);
    #2 rst_n = 1'b1;
    @(negedge wclk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_wen", 32'(tattr_wenable), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_tattr_addr", 32'(tattr_addr), 32'd0);
    check("rst_tattr_wdata", 32'(tattr_wdata), 32'd0);
    for (int i = 0; i < 4; i++) reg_chk("rst_reg", 2'(i), 32'd0);

    // basic 4-byte copy, zero-wait memory
    setup(32'h100, 32'd0, 32'd4);
    push_xfer(32'h100, 0, 4);
    reg_wr(2'd3, 32'h1);
    run_until_idle("t1", 100, cyc);
    check("t1_busy_cycles", 32'(cyc), 32'd8);
    reg_chk("t1_done", 2'd3, 32'h2);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    reg_chk("t1_src_rb", 2'd0, 32'h100);
    reg_chk("t1_len_rb", 2'd2, 32'd4);

    // destination wrap; start+abort in one idle write must start
    setup(32'h200, 32'd1022, 32'd4);
    push_xfer(32'h200, 1022, 4);
    reg_wr(2'd3, 32'h11);
    run_until_idle("t2", 100, cyc);
    check("t2_busy_cycles", 32'(cyc), 32'd8);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // hold off until vertical sync
    setup(32'h300, 32'd10, 32'd2);
    push_xfer(32'h300, 10, 2);
    reg_wr(2'd3, 32'h3);
    r0 = req_cnt;
    repeat (50) @(negedge wclk);
    check("t3_no_req", 32'(req_cnt - r0), 32'd0);
    check("t3_busy_wait", 32'(busy), 32'd1);
    v_sync = 1'b0;
    n = 0;
    do begin
      @(posedge wclk);
      n++;
      @(negedge wclk);
    end while (!mem_req && n < 20);
    check("t3_vs_latency", 32'(n), 32'd3);
    run_until_idle("t3", 100, cyc);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    v_sync = 1'b1;
    repeat (4) @(negedge wclk);

    // slow memory: 5 wait cycles per byte
    ack_delay = 5;
    setup(32'h400, 32'd100, 32'd3);
    push_xfer(32'h400, 100, 3);
    base = wr_cnt;
    reg_wr(2'd3, 32'h1);
    run_until_idle("t4", 200, cyc);
    check("t4_busy_cycles", 32'(cyc), 32'd21);
    check("t4_wr_count", 32'(wr_cnt - base), 32'd3);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    ack_delay = 0;

    // zero length: immediate done, irq, clear
    reg_wr(2'd2, 32'd0);
    r0 = req_cnt;
    reg_wr(2'd3, 32'h9);
    check("t5_irq", 32'(irq), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    reg_chk("t5_status", 2'd3, 32'hA);
    repeat (5) @(negedge wclk);
    check("t5_no_req", 32'(req_cnt - r0), 32'd0);
    reg_wr(2'd3, 32'hC);
    check("t5_irq_clr", 32'(irq), 32'd0);
    reg_chk("t5_status_clr", 2'd3, 32'h8);
    reg_wr(2'd3, 32'h0);

    // abort during REQ of byte 2 of 10; busy restart and SRC write ignored
    ack_delay = 3;
    setup(32'h500, 32'd200, 32'd10);
    push_xfer(32'h500, 200, 3);
    base = wr_cnt;
    reg_wr(2'd3, 32'h1);
    n = 0;
    do begin
      @(negedge wclk);
      n++;
    end while (!(wr_cnt == base + 2 && mem_req) && n < 200);
    check("t6_reach_byte2", 32'(wr_cnt - base), 32'd2);
    reg_wr(2'd3, 32'h10);
    reg_wr(2'd3, 32'h1);
    reg_wr(2'd0, 32'hDEAD);
    run_until_idle("t6", 200, cyc);
    check("t6_wr_count", 32'(wr_cnt - base), 32'd3);
    reg_chk("t6_not_done", 2'd3, 32'h0);
    reg_chk("t6_src_kept", 2'd0, 32'h500);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    ack_delay = 0;

    // asynchronous reset mid-transfer
    setup(32'h600, 32'd0, 32'd10);
    push_xfer(32'h600, 0, 10);
    reg_wr(2'd3, 32'h1);
    repeat (3) @(negedge wclk);
    check("t7_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_req", 32'(mem_req), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_wen", 32'(tattr_wenable), 32'd0);
    sb.delete();
    @(negedge wclk);
    check("t7_rst_wen_hold", 32'(tattr_wenable), 32'd0);
    reg_chk("t7_rst_src", 2'd0, 32'd0);
    @(negedge wclk);
    rst_n = 1'b1;
    repeat (3) @(negedge wclk);
    check("t7_idle_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_attr_dma.md
Name: tile_attr_dma

Overview:
- Byte-copy DMA engine that fills the tile-attribute RAM of the 800x600 tile video unit from system memory.
- The CPU programs source, destination and length through four memory-mapped registers, then starts the transfer.
- The transfer can be held off until the next vertical sync, so that whole-screen tile-map updates are tear-free.
- The engine sits between the system bus (as a read master) and the tattr write port of the video unit (as a writer). The SoC bus mux gives it priority on that port while busy=1.

Parameters:
- TATTR_SIZE, 1024, entries in the tile-attribute RAM; must be a power of two.
- ADDR_W, $clog2(TATTR_SIZE), tattr address width (10 at default).
- LEN_W, ADDR_W+1, length register width; allows lengths 0..TATTR_SIZE.

Ports:
- wclk  in  1  system clock; all logic is on this clock.
- rst_n  in  1  reset, asynchronous, active-low.
- reg_addr  in  2  register select: 0=SRC, 1=DST, 2=LEN, 3=CTRL.
- reg_wdata  in  32  register write data.
- reg_wenable  in  1  register write strobe, one cycle.
- reg_rdata  out  32  register read data (combinational from reg_addr).
- mem_addr  out  32  system-memory byte read address.
- mem_req  out  1  read request.
- mem_ack  in  1  read complete; may be high in the same cycle as mem_req.
- mem_rdata  in  8  read byte, valid while mem_ack=1.
- tattr_addr  out  ADDR_W  tattr write address.
- tattr_wdata  out  8  tattr write data.
- tattr_wenable  out  1  tattr write strobe.
- v_sync  in  1  active-low vertical sync from the pixel-clock domain (asynchronous to wclk).
- busy  out  1  transfer in progress.
- irq  out  1  level interrupt: done & irq_en.

Behaviour:
- Reset values:
  - All registers 0; FSM in IDLE.
  - mem_req=0, tattr_wenable=0, busy=0, irq=0, mem_addr=0, tattr_addr=0, tattr_wdata=0.
  - Synchroniser flops set to 1.
- v_sync synchronisation and edge detect:
  - v_sync passes through a 2-flop synchroniser, then a third flop for edge detection.
  - vs_fall = (prev=1 && sync=0).
- CTRL register:
  - Write bits: bit0 start, bit1 wait_vsync, bit2 clear_done, bit3 irq_en (stored), bit4 abort.
  - Read bits: bit0 busy, bit1 done, bit3 irq_en; all other bits read 0.
- SRC, DST and LEN read back their stored values, zero-extended.
- Writes to SRC, DST or LEN while busy=1 are ignored.
- Start:
  - Ignored when busy=1.
  - When idle: counter cnt is cleared and done is cleared.
  - If LEN=0: done is set the next cycle, no bus activity, busy stays 0.
  - Otherwise the FSM enters WAIT_VS if wait_vsync=1, else REQ.
  - busy=1 from the cycle after the start write.
- FSM states: IDLE, WAIT_VS, REQ, WRITE.
  - WAIT_VS: stays until vs_fall, then goes to REQ.
  - REQ: mem_req=1 and mem_addr=SRC+cnt (32-bit wrap). Holds until mem_ack; on ack, latches mem_rdata and goes to WRITE.
  - WRITE: tattr_wenable=1 for exactly one cycle, with tattr_addr=(DST+cnt) mod TATTR_SIZE and tattr_wdata=the latched byte. Then cnt increments. If cnt+1==LEN, go to IDLE and set done; else go to REQ.
- Throughput is 2 cycles per byte with a zero-wait memory.
- Destination wrap: DST+cnt wraps modulo TATTR_SIZE; e.g. DST=1020, LEN=8 writes entries 1020..1023 then 0..3.
- Abort:
  - Honoured only in WAIT_VS or WRITE. In WRITE the current byte is still written, then the FSM returns to IDLE.
  - done is not set on abort.
  - An abort pending in REQ is held and takes effect at the following WRITE, so the memory handshake is never broken.
  - Abort while idle has no effect.
- Simultaneous events:
  - clear_done and completion in the same cycle: done=1 (completion wins).
  - start and abort in the same write while idle: start wins.
- Asynchronous reset mid-transfer: all outputs return to their reset values immediately; no partial write strobe is produced after reset is asserted.

Decomposition:
- Shared package video_pkg holds:
  - the register offsets;
  - the CTRL bit positions;
  - TATTR_SIZE;
  - the FSM state encoding.
- One sub-module, sync_edge_detect: 2-flop synchroniser plus falling-edge pulse, with a reset value parameter. It is reusable for h_sync.

Test Plan:
- SRC=0x100, DST=0, LEN=4, start, mem_ack tied high:
  - tattr writes at addresses 0,1,2,3 carry the bytes at 0x100..0x103.
  - busy is high for 8 cycles, then done=1.
- DST=1022, LEN=4: writes go to 1022, 1023, 0, 1 in that order.
- wait_vsync=1 and start with v_sync held 1 for 50 cycles:
  - no mem_req during that time;
  - first mem_req occurs 3 cycles after v_sync falls (synchroniser plus edge detect).
- mem_ack delayed 5 cycles per byte:
  - mem_req stays high and mem_addr stays stable until ack;
  - exactly one tattr_wenable per byte.
- LEN=0 start: done=1 next cycle, no mem_req. With irq_en=1, irq rises; clear_done drops it.
- Abort issued during REQ of byte 2 of 10:
  - byte 2 is still written, then IDLE, done=0;
  - a second start while busy is ignored;
  - rst_n asserted mid-transfer immediately zeroes mem_req and busy.
